// File: rtl/uart_rx_if.sv
// Serial receive port bundle: the line in, plus the received byte and its strobes out.
interface uart_rx_if;
  logic       din;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport slave  (input din, output data, output valid, output frame_err, output busy);
  modport master (output din, input data, input valid, input frame_err, input busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, MSB first: mid-bit sampling of a synchronized line,
// one-cycle valid / frame_err strobes.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave rx
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             din_s;

  // Synchronizer resets to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx.din};
  end
  assign din_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!din_s) state_d = START;
      end
      // Half a bit in: still low means a real start bit, and the counter is
      // now aligned so every later full-period wrap lands mid-bit.
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!din_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {shift_q[6:0], din_s};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      // Stop is judged only at mid-bit, which tolerates a shortened stop.
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (din_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      // A held-low break must release before another start can be seen.
      WAIT_IDLE: begin
        cnt_d = '0;
        if (din_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx.data      = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = (state_q != IDLE);
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver paired with the team's 8N1 transmitter (`tx`). Same frame format:
  - idle-high line
  - one low start bit
  - 8 data bits, MSB first
  - high stop bit
  - OVERSAMPLE system clocks per bit
- Takes the asynchronous serial line, recovers each byte by mid-bit sampling, and presents it with a one-cycle valid strobe.
- Sits between the FPGA pin and the user logic that consumes received bytes.

Parameters:
OVERSAMPLE, 16, system clocks per bit period; even, >= 4; must match the transmitter (16)
SYNC_STAGES, 2, flip-flops in the input synchronizer; >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  1  asynchronous serial line, idle high
data  output  8  last correctly framed byte, MSB = first data bit received
valid  output  1  one-cycle pulse; data is updated on the same edge
frame_err  output  1  one-cycle pulse; stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset and interface:
  - One clock (clk). Reset rst is synchronous and active-high.
  - On rst: state = IDLE, all synchronizer flops = 1, counters = 0, data = 8'h00, valid = 0, frame_err = 0, busy = 0. Reset mid-frame abandons the frame and emits no pulse.
- Synchronizer: din passes through SYNC_STAGES flops; din_s is the last stage. All decisions use din_s only.
- Bit counter: cnt, width clog2(OVERSAMPLE), 0 after every state entry. Bit index: bit_idx, 3 bits.
- State IDLE:
  - if din_s == 0 -> START, cnt <= 0.
- State START:
  - cnt increments each clock.
  - At the edge where cnt == OVERSAMPLE/2-1:
    - din_s == 0 -> DATA, cnt <= 0, bit_idx <= 0.
    - din_s == 1 -> glitch; return to IDLE, no pulse.
- State DATA:
  - cnt increments; at the edge where cnt == OVERSAMPLE-1: shift_reg <= {shift_reg[6:0], din_s}, bit_idx++, cnt <= 0.
  - When bit_idx == 7 on that edge -> STOP.
- State STOP:
  - cnt increments; at the edge where cnt == OVERSAMPLE-1, sample din_s.
  - din_s == 1: data <= shift_reg, valid <= 1, go to IDLE. A stop bit only needs to be high at mid-bit, so back-to-back frames with a short stop are accepted.
  - din_s == 0: frame_err <= 1, data unchanged, go to WAIT_IDLE.
- State WAIT_IDLE: stays until din_s == 1, then IDLE. This prevents a held-low break from retriggering.
- Pulse rules:
  - valid and frame_err are registered, high for exactly one clock, and never high together.
  - data holds its value until the next valid.
- Latency (OVERSAMPLE=16, SYNC_STAGES=2):
  - Let edge e0 be the first edge that samples din low.
  - START is entered at e2; start is confirmed at e10.
  - Data bits are sampled at e26 + 16k, for k = 0..7.
  - Stop is sampled at e154; valid is high in the cycle after e154.
- A din low pulse shorter than the start check is rejected without corrupting the previous data.
- busy is combinational from state: low only in IDLE.

Test Plan:
- Reset, then `tx` drives 8'hA5 with OVERSAMPLE=16 -> exactly one valid pulse in the cycle after e154, data == 8'hA5, frame_err never high.
- Back-to-back bytes 8'h00, 8'hFF, 8'h3C via `tx`, each send issued on the first IDLE cycle -> three valid pulses, data sequence 00, FF, 3C, no frame_err.
- din low for 5 clocks, then high -> busy rises, returns to IDLE by e10, no valid/frame_err, data keeps its prior value.
- Frame 8'h81 with the stop bit forced low and line held low 300 clocks -> one frame_err pulse at the stop sample, no valid, busy stays high until din returns high, next good byte 8'h55 is received correctly.
- Assert rst during data bit 4 of 8'hC3 -> busy = 0, data = 00 the cycle after, no pulse. The following frame 8'h5A is received correctly.
- Bit-period jitter: drive 8'h96 with each bit 15 or 17 clocks long, alternating -> data == 8'h96, valid once.
